// File: rtl/dm_responder_pkg.sv
// ---------------------------------------------------------------------------
// dm_responder_pkg
// Shared definitions for the dm_responder slice: the three-state FSM
// encoding, the data word width and the default build parameters.
// Ports: none (package).
// ---------------------------------------------------------------------------
package dm_responder_pkg;

   localparam int DATA_W           = 32;
   localparam int WAIT_CYCLES_DEF  = 2;
   localparam int ADDR_W_DEF       = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dm_responder_if.sv
// ---------------------------------------------------------------------------
// dm_responder_if
// Request/acknowledge bus between a CPU-side initiator and dm_responder.
// Signals:
//   req    initiator -> responder  access request, held until ack
//   we     initiator -> responder  1 = write, 0 = read
//   addr   initiator -> responder  word address
//   wdata  initiator -> responder  write data
//   be     initiator -> responder  byte enables
//   ack    responder -> initiator  one-cycle completion strobe
//   rdata  responder -> initiator  read data, valid with ack
//   busy   responder -> initiator  access in progress
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface dm_responder_if
   import dm_responder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        be;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   modport master (output req, we, addr, wdata, be, input ack, rdata, busy);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata, busy);

endinterface

// File: rtl/dm_responder_ram.sv
// ---------------------------------------------------------------------------
// dm_responder_ram
// Single-port synchronous word memory with per-byte write enables.
// The read register is reset to zero; the storage array is never cleared.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (read register only)
//   en     access strobe for this cycle
//   we     1 = write, 0 = read
//   addr   word address
//   wdata  write data
//   wbe    per-byte write enables
//   rdata  registered read data, updated only by reads
// ---------------------------------------------------------------------------
module dm_responder_ram
   import dm_responder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wbe,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array: byte lanes written independently, no reset so contents
   // survive a reset of the surrounding block.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < 4; i++) begin
            if (wbe[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Read register: only loaded by reads, so writes leave it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
// Memory-mapped responder: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then performs the access and strobes ack.
// Optional feature macro: DM_RESPONDER_BYTE_WR_EN -- when defined, writes
// honour be per byte; otherwise every write updates the full word.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dm_responder_if.slave (req/we/addr/wdata/be in, ack/rdata/busy out)
// ---------------------------------------------------------------------------
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   dm_responder_if.slave  bus
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              accept, enter_resp, ack_c, busy_c;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_q;

   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [3:0]        acc_be;
   logic [3:0]        ram_wbe;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and outputs. Requests are only looked at in IDLE, which
   // gives the one-cycle bubble after every ack.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      enter_resp = 1'b0;
      ack_c      = 1'b0;
      busy_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            busy_c = 1'b1;
            if (cnt <= 4'd1) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            busy_c    = 1'b1;
            ack_c     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Wait counter and payload capture at acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (accept) begin
         cnt     <= WAIT_LOAD;
         we_q    <= bus.we;
         addr_q  <= bus.addr;
         wdata_q <= bus.wdata;
         be_q    <= bus.be;
      end else if (state == WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // With zero wait states the access happens on the acceptance edge itself,
   // so the payload being captured is taken straight from the bus.
   always_comb begin
      if (state == IDLE) begin
         acc_we    = bus.we;
         acc_addr  = bus.addr;
         acc_wdata = bus.wdata;
         acc_be    = bus.be;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
   end

`ifdef DM_RESPONDER_BYTE_WR_EN
   assign ram_wbe = acc_be;
`else
   logic unused_be;
   assign unused_be = ^acc_be;
   assign ram_wbe   = 4'hF;
`endif

   dm_responder_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enter_resp),
      .we    (acc_we),
      .addr  (acc_addr),
      .wdata (acc_wdata),
      .wbe   (ram_wbe),
      .rdata (bus.rdata)
   );

   assign bus.ack  = ack_c;
   assign bus.busy = busy_c;

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and acknowledge (legal range 0..15).
REQ-002 Parameter ADDR_W, default 10: word-address width, giving 2**ADDR_W 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  access request from the CPU-side initiator; held high with stable payload until ack.
REQ-006 we  input  1  1 = write access, 0 = read access.
REQ-007 addr  input  ADDR_W  word address, carried on byte-address bits [ADDR_W+1:2].
REQ-008 wdata  input  32  write data.
REQ-009 be  input  4  byte enables; be[i] qualifies wdata[8i+7:8i].
REQ-010 ack  output  1  one-cycle completion strobe.
REQ-011 rdata  output  32  registered read data, valid while ack=1.
REQ-012 busy  output  1  high from acceptance through the ack cycle.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1 at a rising edge, the block SHALL latch we, addr, wdata and be, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reads 1.
REQ-016 Ack SHALL be high for exactly the RESP cycle, which is cycle WAIT_CYCLES+1 after the acceptance edge; RESP SHALL always return to IDLE.
REQ-017 A write SHALL update memory, and a read SHALL load rdata, on the edge entering RESP, using only the latched payload.
REQ-018 rdata SHALL hold its value outside ack cycles and SHALL NOT change on writes.
REQ-019 Req seen in WAIT or RESP SHALL be ignored; a req still high in the ack cycle SHALL be accepted as a new request on the following IDLE edge (one-cycle bubble, back-to-back throughput 1 per WAIT_CYCLES+2).
REQ-020 busy SHALL be 1 in WAIT and RESP, and 1 in the cycle after acceptance, which is always WAIT or RESP.
REQ-021 Payload changes after acceptance SHALL have no effect on the access in progress.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, ack=0, busy=0, rdata=0 and counter=0, including mid-access.
REQ-023 A write interrupted by reset before the RESP edge SHALL NOT modify memory.
REQ-024 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-025 With DM_RESPONDER_BYTE_WR_EN defined, a write SHALL update only the bytes whose be bit is 1, and be=4'b0000 SHALL complete with ack but write nothing.
REQ-026 Without DM_RESPONDER_BYTE_WR_EN, be SHALL be ignored and every write SHALL update the full word.
REQ-027 Reads SHALL ignore be in both configurations.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/WAIT/RESP), the word-width constant 32, and the default WAIT_CYCLES and ADDR_W.
REQ-029 The storage array SHALL be one sub-module, dm_responder_ram, with a single synchronous read/write port and per-byte write enables; the FSM and counter SHALL remain in the top module.

Verification
REQ-030 Scenario: reset, then write addr=10'h004, wdata=32'hDEADBEEF, be=4'hF, WAIT_CYCLES=2 -> ack high exactly on cycle 3 after acceptance, for 1 cycle; then read addr=10'h004 -> rdata=32'hDEADBEEF with ack.
REQ-031 Scenario: with the macro defined, write 32'h11223344 with be=4'b0101 over existing 32'hAABBCCDD -> read returns 32'hAA22CC44; without the macro -> read returns 32'h11223344.
REQ-032 Scenario: WAIT_CYCLES=0 and req held high for four reads -> ack pulses every 2nd cycle, each with the correct word.
REQ-033 Scenario: payload changed (addr and wdata altered) during WAIT -> access uses the originally latched values, and the new addr is untouched.
REQ-034 Scenario: rst pulsed low mid-WAIT of a write of 32'h0BADF00D to addr 10'h3FF -> ack never asserts, busy=0 at once, and a later read of 10'h3FF returns the prior contents.
REQ-035 Scenario: req driven high while busy=1 from a second source -> ignored, and exactly one ack per accepted request.
